reg_file_param: RTL

REG_FILE_PARAM -- requirements
Module: reg_file_param

---
 rtl/reg_file_param.sv | 149 ++++++++++++++
 1 files changed

// File: rtl/reg_file_param.sv
// -----------------------------------------------------------------------------
// reg_file_param
//
// Purpose
//   Parameterised register file with one write port, two combinational read
//   ports, optional write-to-read forwarding, and a per-register busy
//   scoreboard that tracks destinations claimed by issued instructions and
//   not yet written back. Register 0 reads as zero and can never be busy.
//
// Parameters
//   DATA_W  register width in bits
//   ADDR_W  address width; the file holds 2**ADDR_W registers
//   BYPASS  1: a read of the register being written returns wd in the same
//           cycle; 0: the read returns the stored value until the edge
//
// Ports
//   clk       single clock, all state changes on its rising edge
//   rst_n     asynchronous active-low reset (registers, busy bits, busy_cnt)
//   we        write enable
//   wa, wd    write address / write data
//   ra1, ra2  read addresses
//   rd1, rd2  read data (combinational)
//   iss_en    an instruction issues and claims register iss_dst
//   iss_dst   destination register being claimed
//   flush     clears every pending claim; iss_en is ignored on that edge
//   busy1/2   pending-write status of ra1 / ra2 (masked by a forwarded write)
//   busy_cnt  registered number of busy registers
// -----------------------------------------------------------------------------
module reg_file_param #(
   parameter int DATA_W = 32,
   parameter int ADDR_W = 5,
   parameter int BYPASS = 1
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              we,
   input  logic [ADDR_W-1:0] wa,
   input  logic [DATA_W-1:0] wd,
   input  logic [ADDR_W-1:0] ra1,
   input  logic [ADDR_W-1:0] ra2,
   output logic [DATA_W-1:0] rd1,
   output logic [DATA_W-1:0] rd2,
   input  logic              iss_en,
   input  logic [ADDR_W-1:0] iss_dst,
   input  logic              flush,
   output logic              busy1,
   output logic              busy2,
   output logic [ADDR_W:0]   busy_cnt
);

   localparam int DEPTH = 1 << ADDR_W;

   // Storage and scoreboard state
   logic [DATA_W-1:0] regs_q [DEPTH];
   logic [DEPTH-1:0]  busy_q;
   logic [DEPTH-1:0]  busy_next;
   logic [ADDR_W:0]   cnt_next;

   // Qualified write / issue strobes: address 0 is never a real target
   logic wr_go;
   logic iss_go;

   assign wr_go  = we && (wa != '0);
   assign iss_go = iss_en && (iss_dst != '0);

   // Forwarding hits: only meaningful when BYPASS is enabled
   logic hit1;
   logic hit2;

   assign hit1 = (BYPASS != 0) && wr_go && (wa == ra1);
   assign hit2 = (BYPASS != 0) && wr_go && (wa == ra2);

   // ---------------------------------------------------------------------------
   // Data storage. Register 0 is never written, so it stays at its reset value;
   // the read path still forces 0 explicitly so r0 does not depend on that.
   // ---------------------------------------------------------------------------
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < DEPTH; i++) begin
            regs_q[i] <= '0;
         end
      end else if (wr_go) begin
         regs_q[wa] <= wd;
      end
   end

   // ---------------------------------------------------------------------------
   // Read ports
   // ---------------------------------------------------------------------------
   always_comb begin
      rd1 = '0;
      if (ra1 != '0) begin
         rd1 = hit1 ? wd : regs_q[ra1];
      end
   end

   always_comb begin
      rd2 = '0;
      if (ra2 != '0) begin
         rd2 = hit2 ? wd : regs_q[ra2];
      end
   end

   // ---------------------------------------------------------------------------
   // Scoreboard next state.
   // The clear from a write-back is applied before the set from an issue, so a
   // new producer claiming the register that is completing on the same edge
   // keeps it busy. Flush dominates both and discards the issue.
   // ---------------------------------------------------------------------------
   always_comb begin
      busy_next = busy_q;
      if (flush) begin
         busy_next = '0;
      end else begin
         if (wr_go) begin
            busy_next[wa] = 1'b0;
         end
         if (iss_go) begin
            busy_next[iss_dst] = 1'b1;
         end
      end
      busy_next[0] = 1'b0;
   end

   // Population count of the next busy vector, so the registered count lines
   // up with the busy bits that become visible after the same edge.
   always_comb begin
      cnt_next = '0;
      for (int i = 0; i < DEPTH; i++) begin
         cnt_next = cnt_next + (ADDR_W+1)'(busy_next[i]);
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         busy_q   <= '0;
         busy_cnt <= '0;
      end else begin
         busy_q   <= busy_next;
         busy_cnt <= cnt_next;
      end
   end

   // A register being written this cycle is reported not busy on a forwarding
   // read port, since the value it waits for is already on rd.
   assign busy1 = busy_q[ra1] && !hit1;
   assign busy2 = busy_q[ra2] && !hit2;

endmodule
